dcp_rd_rsp_unit: RTL and testbench
==================================

Name: dcp_rd_rsp_unit

Overview:
- Memory-side responder for the 16x16 read-command crossbar. Sits behind one crossbar output port.
- Consumes Decoupled read commands, issues burst reads to a fixed-latency packet-buffer SRAM, and returns data beats as a Decoupled master.
- Each data beat's Dst is the requesting ingress port, so the response crossbar can route it back.

Parameters:
- AW, 12, address width (equals ADDR_LENTH); command payload width is AW+9.
- DW, 128, SRAM/data beat width.
- SW, 4, source-port field width (16 ports).
- LW, 5, burst-length field width; burst = LEN+1 words.
- DEPTH, 4, output FIFO entries (power of 2, >= MEM_LAT+1).
- MEM_LAT, 1, SRAM read latency in cycles (1 or 2).

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iRdCmdVld  in  1  command valid
- iRdCmdRdy  out  1  command ready
- iRdCmdPld  in  AW+9  {len[LW-1:0], src[SW-1:0], addr[AW-1:0]}
- iRdCmdDst  in  4  crossbar destination index; ignored
- oMemRdEn  out  1  SRAM read strobe
- oMemRdAddr  out  AW  SRAM read address
- iMemRdData  in  DW  SRAM data, valid MEM_LAT cycles after oMemRdEn
- oRdDatVld  out  1  data beat valid
- iRdDatRdy  in  1  data beat ready
- oRdDatPld  out  DW+1  {last, data}
- oRdDatDst  out  SW  requester port (cmd src)

Behaviour:
- Reset values: iRdCmdRdy=0 during reset, 1 in the first cycle after reset; oMemRdEn=0, oMemRdAddr=0, oRdDatVld=0, oRdDatPld=0, oRdDatDst=0.
- Handshake: a transfer occurs on Vld&Rdy at a clock edge.
  - Vld never depends on Rdy.
  - Once raised, oRdDatVld, oRdDatPld and oRdDatDst hold until accepted.
- FSM states:
  - IDLE: iRdCmdRdy=1. On accept, latch addr/src/len, set beat counter=0, go to BURST.
  - BURST: iRdCmdRdy=0. Issue one read per cycle while credit is available.
    - On issuing the beat where counter==len, return to IDLE in the next cycle.
    - Otherwise increment counter and addr.
- Credit rule: issue allowed iff inflight + fifo_count < DEPTH.
  - inflight = reads issued whose data has not yet returned.
  - No FIFO overflow is possible under any iRdDatRdy pattern.
- Address arithmetic: oMemRdAddr = base + counter, modulo 2^AW; 0xFFF+1 wraps to 0x000.
- Data path:
  - A MEM_LAT-deep valid/src/last shift pipeline tags each read.
  - On pipeline exit, {last, iMemRdData} and src are pushed into the FIFO.
  - The FIFO head drives the oRdDat* outputs.
- Latency: command accept -> first oMemRdEn = 1 cycle; oMemRdEn -> oRdDatVld = MEM_LAT+1 cycles (registered FIFO output).
- Throughput: with iRdDatRdy=1 continuously, 1 beat/cycle within a burst. Without the optional feature, one idle cycle occurs between bursts (IDLE accept cycle).
- last=1 only on beat LEN of each burst. LEN=0 gives a single beat with last=1.
- Simultaneous FIFO push and pop when full or empty: both take effect; count is unchanged; pop-then-push ordering is preserved.
- Beats leave strictly in command order; no reordering across bursts.
- Reset mid-burst: FSM returns to IDLE; counter, FIFO, inflight and pipeline are cleared; SRAM data returning after reset is discarded.

Optional Feature:
- Macro: DCP_RDRSP_CMD_SKID_EN.
- Defined:
  - Adds a 1-entry command skid register; iRdCmdRdy = skid empty, including while in BURST.
  - On the last issue of a burst, a buffered command loads directly and BURST continues, so back-to-back bursts issue reads with no gap.
  - Reset clears the skid register.
- Undefined: no skid register; commands are accepted only in IDLE, as above.

Decomposition:
- Package dcp_rdrsp_pkg holds:
  - typedef rd_cmd_t as a packed struct {len, src, addr}
  - typedef rd_beat_t as {last, data}
  - localparams for the default widths
  - enum fsm_t {IDLE, BURST}
- Sub-module dcp_rdrsp_fifo: parameterised synchronous FIFO (width, DEPTH) with registered output, full/empty and count.

Test Plan:
- Single beat: cmd addr=0x010, src=3, len=0 -> one oMemRdEn at 0x010; one beat with Dst=3 and last=1, arriving MEM_LAT+1 cycles after the read.
- Burst with steady sink: len=7, addr=0x100, iRdDatRdy=1 -> reads at 0x100..0x107 on consecutive cycles; 8 beats, last only on the 8th.
- Backpressure: len=15, iRdDatRdy toggled 1-in-3 -> oMemRdEn stalls once inflight+count=4; all 16 beats arrive in order, no loss or duplication; outputs stable while stalled.
- Address wrap: addr=0xFFE, len=3 -> reads at 0xFFE, 0xFFF, 0x000, 0x001.
- Back-to-back commands: src=1 len=1, then src=9 len=2 -> beat Dsts 1,1,9,9,9. One gap cycle without DCP_RDRSP_CMD_SKID_EN; zero gap cycles with it.
- Reset mid-burst: assert iRst for 1 cycle at beat 3 of len=7 -> all outputs return to reset values and no stale beat appears; a following cmd len=0 completes normally.

Source files
------------

// File: rtl/dcp_rdrsp_pkg.sv
// Shared widths and types for the read-response unit and its output FIFO.
package dcp_rdrsp_pkg;

  localparam int unsigned AW_DEF      = 12;
  localparam int unsigned DW_DEF      = 128;
  localparam int unsigned SW_DEF      = 4;
  localparam int unsigned LW_DEF      = 5;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned MEM_LAT_DEF = 1;

  typedef struct packed {
    logic [LW_DEF-1:0] len;
    logic [SW_DEF-1:0] src;
    logic [AW_DEF-1:0] addr;
  } rd_cmd_t;

  typedef struct packed {
    logic              last;
    logic [DW_DEF-1:0] data;
  } rd_beat_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fsm_t;

endpackage

// File: rtl/dcp_rdrsp_fifo.sv
// Synchronous FIFO with head-of-queue output, full/empty flags and occupancy count.
module dcp_rdrsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iPushData,
  input  logic                     iPop,
  output logic [WIDTH-1:0]         oHeadData,
  output logic                     oEmpty,
  output logic                     oFull,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [PW-1:0]    wrPtrQ, rdPtrQ;
  logic [PW:0]      cntQ;
  logic             doPush, doPop;

  assign oEmpty    = (cntQ == '0);
  assign oFull     = (cntQ == (PW+1)'(DEPTH));
  assign oCount    = cntQ;
  assign oHeadData = memQ[rdPtrQ];

  // A pop frees its slot in the same cycle, so push is allowed when full and popping.
  assign doPop  = iPop && !oEmpty;
  assign doPush = iPush && (!oFull || doPop);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + PW'(1);
      if (doPop)  rdPtrQ <= rdPtrQ + PW'(1);
      case ({doPush, doPop})
        2'b10:   cntQ <= cntQ + (PW+1)'(1);
        2'b01:   cntQ <= cntQ - (PW+1)'(1);
        default: cntQ <= cntQ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (doPush) memQ[wrPtrQ] <= iPushData;
  end

endmodule

// File: rtl/dcp_rd_rsp_unit.sv
// Read-response unit: turns burst read commands into SRAM reads and returns tagged beats.
// Optional 1-entry command skid register for gapless back-to-back bursts: DCP_RDRSP_CMD_SKID_EN.
module dcp_rd_rsp_unit
  import dcp_rdrsp_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned SW      = SW_DEF,
  parameter int unsigned LW      = LW_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iRdCmdVld,
  output logic                iRdCmdRdy,
  input  logic [AW+SW+LW-1:0] iRdCmdPld,
  input  logic [3:0]          iRdCmdDst,
  output logic                oMemRdEn,
  output logic [AW-1:0]       oMemRdAddr,
  input  logic [DW-1:0]       iMemRdData,
  output logic                oRdDatVld,
  input  logic                iRdDatRdy,
  output logic [DW:0]         oRdDatPld,
  output logic [SW-1:0]       oRdDatDst
);

  localparam int unsigned PW   = AW + SW + LW;
  localparam int unsigned FW   = DW + 1 + SW;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned SUMW = CW + 1;
  localparam logic [0:0]  StIdle  = 1'(IDLE);
  localparam logic [0:0]  StBurst = 1'(BURST);

  logic [0:0]         stateQ, stateD;
  logic [AW-1:0]      addrQ, addrD;
  logic [SW-1:0]      srcQ, srcD;
  logic [LW-1:0]      lenQ, lenD, cntQ, cntD;
  logic               loadVld;
  logic [PW-1:0]      loadCmd;
  logic               cmdAcc, issue, lastIssue;
  logic [MEM_LAT-1:0] pipeVldQ, pipeLastQ;
  logic [SW-1:0]      pipeSrcQ [MEM_LAT];
  logic [CW-1:0]      inflight, fifoCnt;
  logic [SUMW-1:0]    credSum;
  logic               fifoEmpty, unusedFifoFull, fifoPop;
  logic [FW-1:0]      fifoHead;
  logic               unusedDst;

  assign unusedDst = ^iRdCmdDst;

`ifdef DCP_RDRSP_CMD_SKID_EN
  logic          skidVldQ, skidVldD;
  logic [PW-1:0] skidCmdQ, skidCmdD;
  assign iRdCmdRdy = !skidVldQ && !iRst;
`else
  assign iRdCmdRdy = (stateQ == StIdle) && !iRst;
`endif

  assign cmdAcc = iRdCmdVld && iRdCmdRdy;

  // Credit: reads in the SRAM pipeline plus queued beats may never exceed the FIFO depth.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(MEM_LAT); i++) inflight = inflight + CW'(pipeVldQ[i]);
  end

  assign credSum    = SUMW'(inflight) + SUMW'(fifoCnt);
  assign issue      = (stateQ == StBurst) && (credSum < SUMW'(DEPTH));
  assign lastIssue  = issue && (cntQ == lenQ);
  assign oMemRdEn   = issue;
  assign oMemRdAddr = addrQ;

  always_comb begin
    stateD  = stateQ;
    addrD   = addrQ;
    srcD    = srcQ;
    lenD    = lenQ;
    cntD    = cntQ;
    loadVld = 1'b0;
    loadCmd = iRdCmdPld;
`ifdef DCP_RDRSP_CMD_SKID_EN
    skidVldD = skidVldQ;
    skidCmdD = skidCmdQ;
`endif
    case (stateQ)
      StIdle: loadVld = cmdAcc;
      StBurst: begin
        if (lastIssue) begin
          stateD = StIdle;
`ifdef DCP_RDRSP_CMD_SKID_EN
          if (skidVldQ) begin
            loadVld  = 1'b1;
            loadCmd  = skidCmdQ;
            skidVldD = 1'b0;
          end else begin
            loadVld = cmdAcc;
          end
`endif
        end else begin
          if (issue) begin
            cntD  = cntQ + LW'(1);
            addrD = addrQ + AW'(1);
          end
`ifdef DCP_RDRSP_CMD_SKID_EN
          if (cmdAcc) begin
            skidVldD = 1'b1;
            skidCmdD = iRdCmdPld;
          end
`endif
        end
      end
      default: stateD = StIdle;
    endcase
    if (loadVld) begin
      stateD               = StBurst;
      {lenD, srcD, addrD}  = loadCmd;
      cntD                 = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ <= StIdle;
      addrQ  <= '0;
      srcQ   <= '0;
      lenQ   <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      srcQ   <= srcD;
      lenQ   <= lenD;
      cntQ   <= cntD;
    end
  end

`ifdef DCP_RDRSP_CMD_SKID_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      skidVldQ <= 1'b0;
      skidCmdQ <= '0;
    end else begin
      skidVldQ <= skidVldD;
      skidCmdQ <= skidCmdD;
    end
  end
`endif

  // Tag each read with src/last until its data emerges from the SRAM.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pipeVldQ  <= '0;
      pipeLastQ <= '0;
      for (int i = 0; i < int'(MEM_LAT); i++) pipeSrcQ[i] <= '0;
    end else begin
      pipeVldQ[0]  <= issue;
      pipeLastQ[0] <= lastIssue;
      pipeSrcQ[0]  <= srcQ;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipeVldQ[i]  <= pipeVldQ[i-1];
        pipeLastQ[i] <= pipeLastQ[i-1];
        pipeSrcQ[i]  <= pipeSrcQ[i-1];
      end
    end
  end

  assign fifoPop = oRdDatVld && iRdDatRdy;

  dcp_rdrsp_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) uFifo (
    .iClk      (iClk),
    .iRst      (iRst),
    .iPush     (pipeVldQ[MEM_LAT-1]),
    .iPushData ({pipeLastQ[MEM_LAT-1], iMemRdData, pipeSrcQ[MEM_LAT-1]}),
    .iPop      (fifoPop),
    .oHeadData (fifoHead),
    .oEmpty    (fifoEmpty),
    .oFull     (unusedFifoFull),
    .oCount    (fifoCnt)
  );

  assign oRdDatVld = !fifoEmpty;
  assign oRdDatPld = fifoEmpty ? '0 : fifoHead[FW-1:SW];
  assign oRdDatDst = fifoEmpty ? '0 : fifoHead[SW-1:0];

endmodule

// File: tb/tb_dcp_rd_rsp_unit.sv
// Bench for dcp_rd_rsp_unit: directed scenarios plus random commands and sink stalls,
// scored against a burst-level model of reads, beats and credit.
`timescale 1ns/1ps
module tb_dcp_rd_rsp_unit;

  localparam int unsigned AW      = 12;
  localparam int unsigned DW      = 128;
  localparam int unsigned SW      = 4;
  localparam int unsigned LW      = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MEM_LAT = 1;
`ifdef DCP_RDRSP_CMD_SKID_EN
  localparam int GAP_EXP = 0;
`else
  localparam int GAP_EXP = 1;
`endif

  typedef struct {
    logic          last;
    logic [DW-1:0] data;
    logic [SW-1:0] dst;
  } beat_t;

  logic                iClk = 1'b0;
  logic                iRst = 1'b1;
  logic                iRdCmdVld, iRdCmdRdy;
  logic [AW+SW+LW-1:0] iRdCmdPld;
  logic [3:0]          iRdCmdDst;
  logic                oMemRdEn;
  logic [AW-1:0]       oMemRdAddr;
  logic [DW-1:0]       iMemRdData;
  logic                oRdDatVld;
  logic                iRdDatRdy = 1'b1;
  logic [DW:0]         oRdDatPld;
  logic [SW-1:0]       oRdDatDst;

  int checks = 0, errors = 0;
  int cyc = 0, rdCount = 0, firstRd = 0, lastRd = 0;
  int outst = 0, maxOut = 0, rdyMode = 0, ph = 0;

  beat_t         expQ[$];
  logic [AW-1:0] addrQ[$];
  beat_t         b;
  logic [AW-1:0] ea, mAddr;
  logic [SW-1:0] mSrc;
  logic [LW-1:0] mLen;
  logic          holdVld = 1'b0;
  logic [DW:0]   holdPld;
  logic [SW-1:0] holdDst;
  logic [AW-1:0] sramPipe [MEM_LAT];

  dcp_rd_rsp_unit dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iRdCmdVld  (iRdCmdVld),
    .iRdCmdRdy  (iRdCmdRdy),
    .iRdCmdPld  (iRdCmdPld),
    .iRdCmdDst  (iRdCmdDst),
    .oMemRdEn   (oMemRdEn),
    .oMemRdAddr (oMemRdAddr),
    .iMemRdData (iMemRdData),
    .oRdDatVld  (oRdDatVld),
    .iRdDatRdy  (iRdDatRdy),
    .oRdDatPld  (oRdDatPld),
    .oRdDatDst  (oRdDatDst)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc++;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1 ^ 32'h5A5A1234;
    return {h, ~h, h ^ 32'hFFFF0000, 20'hABCDE, a};
  endfunction

  // Fixed-latency SRAM returning a per-address signature.
  always @(posedge iClk) begin
    sramPipe[0] <= oMemRdAddr;
    for (int i = 1; i < MEM_LAT; i++) sramPipe[i] <= sramPipe[i-1];
  end
  assign iMemRdData = memWord(sramPipe[MEM_LAT-1]);

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted command expands into its read addresses and beats.
  always @(negedge iClk) begin
    if (iRst) begin
      expQ.delete();
      addrQ.delete();
      outst   = 0;
      holdVld = 1'b0;
    end else begin
      if (holdVld)
        check("hold_stable", 192'({oRdDatVld, oRdDatPld, oRdDatDst}), 192'({1'b1, holdPld, holdDst}));
      if (oMemRdEn) begin
        check("credit", 192'(outst < DEPTH), 192'(1));
        check("rd_expected", 192'(addrQ.size() != 0), 192'(1));
        if (addrQ.size() != 0) begin
          ea = addrQ.pop_front();
          check("rd_addr", 192'(oMemRdAddr), 192'(ea));
        end
        rdCount++;
        if (rdCount == 1) firstRd = cyc;
        lastRd = cyc;
      end
      if (oRdDatVld && iRdDatRdy) begin
        check("beat_expected", 192'(expQ.size() != 0), 192'(1));
        if (expQ.size() != 0) begin
          b = expQ.pop_front();
          check("beat", 192'({oRdDatPld, oRdDatDst}), 192'({b.last, b.data, b.dst}));
        end
      end
      if (outst > maxOut) maxOut = outst;
      outst   = outst + int'(oMemRdEn) - int'(oRdDatVld && iRdDatRdy);
      holdVld = oRdDatVld && !iRdDatRdy;
      holdPld = oRdDatPld;
      holdDst = oRdDatDst;
      if (iRdCmdVld && iRdCmdRdy) begin
        {mLen, mSrc, mAddr} = iRdCmdPld;
        for (int i = 0; i <= int'(mLen); i++) begin
          ea = AW'(int'(mAddr) + i);
          addrQ.push_back(ea);
          expQ.push_back('{last: (i == int'(mLen)), data: memWord(ea), dst: mSrc});
        end
      end
    end
  end

  // Sink ready pattern: 0 = always, 1 = one cycle in three, else ~70% random.
  initial begin
    forever begin
      @(posedge iClk);
      #1;
      case (rdyMode)
        0: iRdDatRdy = 1'b1;
        1: begin
          iRdDatRdy = (ph == 2);
          ph = (ph + 1) % 3;
        end
        default: iRdDatRdy = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic sendCmd(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [LW-1:0] l);
    bit done;
    done      = 1'b0;
    iRdCmdVld = 1'b1;
    iRdCmdPld = {l, s, a};
    iRdCmdDst = 4'($urandom);
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge iClk);
      done = iRdCmdRdy && !iRst;
      @(posedge iClk);
      #1;
    end
    iRdCmdVld = 1'b0;
    check("cmd_accept", 192'(done), 192'(1));
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge iClk);
      #1;
      done = (expQ.size() == 0) && (addrQ.size() == 0) && !oRdDatVld;
    end
    check("drain", 192'(done), 192'(1));
    @(posedge iClk);
    #1;
  endtask

  initial begin
    iRdCmdVld = 1'b0;
    iRdCmdPld = '0;
    iRdCmdDst = '0;

    // Reset state
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_cmdrdy", 192'(iRdCmdRdy), 192'(0));
    check("rst_rden",   192'(oMemRdEn), 192'(0));
    check("rst_rdaddr", 192'(oMemRdAddr), 192'(0));
    check("rst_vld",    192'(oRdDatVld), 192'(0));
    check("rst_pld",    192'(oRdDatPld), 192'(0));
    check("rst_dst",    192'(oRdDatDst), 192'(0));
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    @(negedge iClk);
    check("cmdrdy_after_rst", 192'(iRdCmdRdy), 192'(1));
    @(posedge iClk);
    #1;

    // Single beat with latency checks
    sendCmd(12'h010, 4'd3, 5'd0);
    @(negedge iClk);
    check("t1_rden_lat", 192'(oMemRdEn), 192'(1));
    check("t1_addr", 192'(oMemRdAddr), 192'(12'h010));
    repeat (MEM_LAT) begin
      @(negedge iClk);
      check("t1_vld_early", 192'(oRdDatVld), 192'(0));
    end
    @(negedge iClk);
    check("t1_vld", 192'(oRdDatVld), 192'(1));
    check("t1_dst", 192'(oRdDatDst), 192'(3));
    check("t1_last", 192'(oRdDatPld[DW]), 192'(1));
    @(posedge iClk);
    #1;
    waitDrain();

    // Steady-sink burst: eight consecutive reads
    rdCount = 0;
    sendCmd(12'h100, 4'd2, 5'd7);
    waitDrain();
    check("t2_reads", 192'(rdCount), 192'(8));
    check("t2_span", 192'(lastRd - firstRd), 192'(7));

    // Backpressure: credit limit reached, order preserved
    rdyMode = 1;
    maxOut  = 0;
    sendCmd(12'($urandom), 4'd6, 5'd15);
    waitDrain();
    check("t3_credit_full", 192'(maxOut), 192'(DEPTH));
    rdyMode = 0;

    // Address wrap
    rdCount = 0;
    sendCmd(12'hFFE, 4'hA, 5'd3);
    waitDrain();
    check("t4_reads", 192'(rdCount), 192'(4));

    // Back-to-back commands
    rdCount = 0;
    sendCmd(12'($urandom), 4'd1, 5'd1);
    sendCmd(12'($urandom), 4'd9, 5'd2);
    waitDrain();
    check("t5_reads", 192'(rdCount), 192'(5));
    check("t5_gap", 192'(lastRd - firstRd + 1 - 5), 192'(GAP_EXP));

    // Reset in the middle of a burst
    rdCount = 0;
    sendCmd(12'h200, 4'd7, 5'd7);
    for (int n = 0; n < 100 && rdCount < 3; n++) begin
      @(negedge iClk);
      #1;
    end
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    @(negedge iClk);
    check("t6_cmdrdy", 192'(iRdCmdRdy), 192'(1));
    check("t6_rden",   192'(oMemRdEn), 192'(0));
    check("t6_rdaddr", 192'(oMemRdAddr), 192'(0));
    check("t6_vld",    192'(oRdDatVld), 192'(0));
    check("t6_pld",    192'(oRdDatPld), 192'(0));
    check("t6_dst",    192'(oRdDatDst), 192'(0));
    repeat (5) begin
      @(negedge iClk);
      check("t6_stale_beat", 192'(oRdDatVld), 192'(0));
    end
    @(posedge iClk);
    #1;
    sendCmd(12'h020, 4'd5, 5'd0);
    waitDrain();

    // Random commands under random sink stalls
    rdyMode = 2;
    repeat (25) sendCmd(12'($urandom), 4'($urandom), 5'($urandom));
    waitDrain();
    rdyMode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
